// File: rtl/reglk_pkg.sv
// Shared types and constants for the register-lock commit block.
// Holds the commit FSM state encoding, the lock byte width and the
// default peripheral count / acknowledge timeout.
package reglk_pkg;

    localparam int unsigned LK_BYTE_W          = 8;
    localparam int unsigned NB_PERIPHERALS_DEF = 14;
    localparam int unsigned ACK_TIMEOUT_DEF    = 255;
    localparam int unsigned WAIT_CNT_W         = 16;

    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/reglk_timeout_cnt.sv
// Acknowledge wait counter for the lock commit FSM.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clr           : force the count back to zero (has priority over en)
//   en            : count one waiting cycle
//   limit         : number of waiting cycles allowed (1..2^CNT_W-1)
//   expired_c     : high in the waiting cycle that reaches the limit
module reglk_timeout_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expired_c
);

    logic [CNT_W-1:0] cnt_q;

    // Count holds the number of completed waiting cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The cycle currently being counted is the limit-th one.
    assign expired_c = en && (cnt_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/reglk_commit.sv
// Register-lock commit stage. Scans the raw lock bytes round-robin and, for a
// peripheral whose lock byte would gain bits, requests an update and commits
// the snapshotted byte once the peripheral acknowledges (or after a timeout,
// so that locks are never withheld). Lock bits only ever get set here; they
// are cleared by reset or jtag_unlock.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   jtag_unlock   : clears all committed locks on the next edge
//   reglk_raw_i   : raw lock bytes, byte i for peripheral i
//   reglk_ctrl_o  : committed lock bytes (registered)
//   upd_req_o     : one-hot update request, level
//   upd_ack_i     : per-peripheral ready acknowledge
//   busy_o        : request outstanding
//   err_o         : sticky acknowledge-timeout flag
//   err_idx_o     : peripheral of the most recent timeout
// NB_PERIPHERALS must be at least 2; ACK_TIMEOUT must be in 1..65535.
module reglk_commit
    import reglk_pkg::*;
#(
    parameter int unsigned NB_PERIPHERALS = NB_PERIPHERALS_DEF,
    parameter int unsigned ACK_TIMEOUT    = ACK_TIMEOUT_DEF
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   jtag_unlock,
    input  logic [LK_BYTE_W*NB_PERIPHERALS-1:0]    reglk_raw_i,
    output logic [LK_BYTE_W*NB_PERIPHERALS-1:0]    reglk_ctrl_o,
    output logic [NB_PERIPHERALS-1:0]              upd_req_o,
    input  logic [NB_PERIPHERALS-1:0]              upd_ack_i,
    output logic                                   busy_o,
    output logic                                   err_o,
    output logic [$clog2(NB_PERIPHERALS)-1:0]      err_idx_o
);

    localparam int unsigned     IDX_W    = $clog2(NB_PERIPHERALS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_PERIPHERALS - 1);

    state_e                                    state_q;
    logic [IDX_W-1:0]                          idx_q;
    logic [IDX_W-1:0]                          idx_nxt_c;
    logic [NB_PERIPHERALS-1:0][LK_BYTE_W-1:0]  raw_c;
    logic [NB_PERIPHERALS-1:0][LK_BYTE_W-1:0]  commit_q;
    logic [LK_BYTE_W-1:0]                      staging_q;
    logic [LK_BYTE_W-1:0]                      target_c;
    logic                                      change_c;
    logic                                      ack_c;
    logic                                      cnt_clr_c;
    logic                                      cnt_en_c;
    logic                                      expired_c;

    assign raw_c        = reglk_raw_i;
    assign reglk_ctrl_o = commit_q;

    // Monotonic target: raw bits can add locks but never remove committed ones.
    assign target_c  = raw_c[idx_q] | commit_q[idx_q];
    assign change_c  = (target_c != commit_q[idx_q]);
    assign ack_c     = upd_ack_i[idx_q];
    assign idx_nxt_c = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    // Counter idles at zero outside WAIT, so it starts from zero on entry.
    assign cnt_clr_c = (state_q != ST_WAIT) || jtag_unlock;
    assign cnt_en_c  = (state_q == ST_WAIT) && !ack_c;

    reglk_timeout_cnt #(
        .CNT_W (WAIT_CNT_W)
    ) u_timeout_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr       (cnt_clr_c),
        .en        (cnt_en_c),
        .limit     (WAIT_CNT_W'(ACK_TIMEOUT)),
        .expired_c (expired_c)
    );

    // Scan / wait FSM with registered request, busy and error outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_SCAN;
            idx_q     <= '0;
            commit_q  <= '0;
            staging_q <= '0;
            upd_req_o <= '0;
            busy_o    <= 1'b0;
            err_o     <= 1'b0;
            err_idx_o <= '0;
        end else if (jtag_unlock) begin
            // Error history survives an unlock on purpose.
            state_q   <= ST_SCAN;
            idx_q     <= '0;
            commit_q  <= '0;
            staging_q <= '0;
            upd_req_o <= '0;
            busy_o    <= 1'b0;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    if (change_c) begin
                        staging_q <= target_c;
                        upd_req_o <= NB_PERIPHERALS'(1) << idx_q;
                        busy_o    <= 1'b1;
                        state_q   <= ST_WAIT;
                    end else begin
                        idx_q <= idx_nxt_c;
                    end
                end
                ST_WAIT: begin
                    // Ack wins over a coinciding timeout; a timeout still
                    // commits so the lock is never held back.
                    if (ack_c || expired_c) begin
                        commit_q[idx_q] <= staging_q;
                        upd_req_o       <= '0;
                        busy_o          <= 1'b0;
                        idx_q           <= idx_nxt_c;
                        state_q         <= ST_SCAN;
                        if (!ack_c) begin
                            err_o     <= 1'b1;
                            err_idx_o <= idx_q;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reglk_commit.sv
// Self-checking bench for reglk_commit: directed transaction table, a few
// hand-written corner sequences, and a randomized run checked against a
// transaction-level model of the lock commit rules.
module tb_reglk_commit;

    localparam int NB   = 14;
    localparam int TO   = 4;
    localparam int NONE = 255;
    localparam logic [NB-1:0] ONE = 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 jtag;
    logic [NB-1:0][7:0]   raw;
    logic [NB-1:0]        ack;
    logic [8*NB-1:0]      ctrl;
    logic [NB-1:0]        req;
    logic                 busy;
    logic                 err;
    logic [3:0]           eidx;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    reglk_commit #(
        .NB_PERIPHERALS (NB),
        .ACK_TIMEOUT    (TO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .jtag_unlock  (jtag),
        .reglk_raw_i  (raw),
        .reglk_ctrl_o (ctrl),
        .upd_req_o    (req),
        .upd_ack_i    (ack),
        .busy_o       (busy),
        .err_o        (err),
        .err_idx_o    (eidx)
    );

    typedef struct {
        int         idx;
        logic [7:0] raw_val;
        int         ack_dly;
        int         stray;
        logic [7:0] exp_byte;
        int         exp_cyc;
        bit         exp_err;
        int         exp_eidx;
    } vec_t;

    vec_t tbl[8];
    logic [NB-1:0][7:0] exp_ctrl;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int i, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3 * NB; c++) begin
            step();
            if (req != '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("req_rise", req, ONE << i);
    endtask

    // Transaction-level reference model state
    logic [NB-1:0][7:0] m_comm;
    int                 m_req;
    logic [7:0]         m_stage;
    int                 m_wait;
    bit                 m_err;
    int                 m_eidx;

    initial begin
        bit ok;
        int cyc;
        int streak;
        logic [NB-1:0][7:0] p_raw, pp_raw;
        logic [NB-1:0]      p_ack;
        logic               p_jtag;

        tbl[0] = '{idx: 3,  raw_val: 8'h05, ack_dly: 2,    stray: -1, exp_byte: 8'h05, exp_cyc: 3, exp_err: 0, exp_eidx: 0};
        tbl[1] = '{idx: 2,  raw_val: 8'h0F, ack_dly: 0,    stray: -1, exp_byte: 8'h0F, exp_cyc: 1, exp_err: 0, exp_eidx: 0};
        tbl[2] = '{idx: 2,  raw_val: 8'h30, ack_dly: 1,    stray: -1, exp_byte: 8'h3F, exp_cyc: 2, exp_err: 0, exp_eidx: 0};
        tbl[3] = '{idx: 4,  raw_val: 8'h81, ack_dly: 3,    stray: 9,  exp_byte: 8'h81, exp_cyc: 4, exp_err: 0, exp_eidx: 0};
        tbl[4] = '{idx: 7,  raw_val: 8'h01, ack_dly: NONE, stray: -1, exp_byte: 8'h01, exp_cyc: 4, exp_err: 1, exp_eidx: 7};
        tbl[5] = '{idx: 11, raw_val: 8'hA0, ack_dly: 0,    stray: -1, exp_byte: 8'hA0, exp_cyc: 1, exp_err: 1, exp_eidx: 7};
        tbl[6] = '{idx: 13, raw_val: 8'hFF, ack_dly: 1,    stray: -1, exp_byte: 8'hFF, exp_cyc: 2, exp_err: 1, exp_eidx: 7};
        tbl[7] = '{idx: 0,  raw_val: 8'h10, ack_dly: 5,    stray: -1, exp_byte: 8'h10, exp_cyc: 4, exp_err: 1, exp_eidx: 0};

        // Reset with busy raw inputs: everything must come up zero
        rst_n = 1'b0;
        jtag  = 1'b0;
        ack   = '0;
        for (int i = 0; i < NB; i++) raw[i] = 8'($urandom_range(1, 255));
        step();
        step();
        chk("rst_ctrl", ctrl, 0);
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_eidx", eidx, 0);
        raw   = '0;
        rst_n = 1'b1;

        // Idle scanning with raw zero never requests
        for (int c = 0; c < 40; c++) begin
            step();
            chk("idle_req", {busy, req}, 0);
        end
        chk("idle_ctrl", ctrl, 0);

        // Directed transactions
        exp_ctrl = '0;
        for (int v = 0; v < 8; v++) begin
            raw[tbl[v].idx] = tbl[v].raw_val;
            if (tbl[v].stray >= 0) ack[tbl[v].stray] = 1'b1;
            wait_req(tbl[v].idx, ok);
            chk("req_busy", busy, 1);
            cyc = 0;
            if (ok) begin
                while (cyc < 12) begin
                    if (cyc == tbl[v].ack_dly) ack[tbl[v].idx] = 1'b1;
                    step();
                    cyc++;
                    if (!req[tbl[v].idx]) break;
                end
            end
            exp_ctrl[tbl[v].idx] = tbl[v].exp_byte;
            chk("txn_cycles", cyc, tbl[v].exp_cyc);
            chk("txn_ctrl", ctrl, exp_ctrl);
            chk("txn_req", {busy, req}, 0);
            chk("txn_err", err, tbl[v].exp_err);
            chk("txn_eidx", eidx, tbl[v].exp_eidx);
            ack = '0;
            raw[tbl[v].idx] = 8'h00;
        end

        // Raw dropping to zero or to a subset of committed bits never requests
        raw[2] = 8'h00;
        for (int c = 0; c < 2 * NB; c++) begin
            step();
            chk("mono_zero_req", req, 0);
        end
        raw[2] = 8'h0F;
        for (int c = 0; c < 2 * NB; c++) begin
            step();
            chk("mono_sub_req", req, 0);
        end
        chk("mono_ctrl", ctrl, exp_ctrl);
        raw[2] = 8'h00;

        // jtag_unlock during WAIT clears locks but keeps error history
        raw[5] = 8'h22;
        wait_req(5, ok);
        jtag = 1'b1;
        step();
        jtag   = 1'b0;
        raw[5] = 8'h00;
        chk("jtag_ctrl", ctrl, 0);
        chk("jtag_req", {busy, req}, 0);
        chk("jtag_err", err, 1);
        chk("jtag_eidx", eidx, 0);
        for (int c = 0; c < 2 * NB; c++) step();
        chk("jtag_after_req", req, 0);

        // Reset mid-WAIT beats ack and jtag and clears the error
        raw[3] = 8'h44;
        raw[6] = 8'h44;
        wait_req(3, ok);
        rst_n  = 1'b0;
        ack[3] = 1'b1;
        jtag   = 1'b1;
        step();
        chk("rstw_ctrl", ctrl, 0);
        chk("rstw_req", {busy, req}, 0);
        chk("rstw_err", {err, eidx}, 0);
        rst_n = 1'b1;
        jtag  = 1'b0;
        ack   = '0;
        raw   = '0;
        step();
        step();
        chk("rstw_after", {ctrl, req}, 0);

        // Randomized run against the transaction-level model
        m_comm = '0;
        m_req  = -1;
        m_stage = '0;
        m_wait = 0;
        m_err  = 1'b0;
        m_eidx = 0;
        streak = 0;
        pp_raw = raw;
        for (int c = 0; c < 3000; c++) begin
            bit pending;
            p_raw  = raw;
            p_ack  = ack;
            p_jtag = jtag;
            step();

            pending = 1'b0;
            for (int j = 0; j < NB; j++)
                if ((p_raw[j] | m_comm[j]) != m_comm[j]) pending = 1'b1;

            if (p_jtag) begin
                m_comm = '0;
                m_req  = -1;
                streak = 0;
            end else if (m_req >= 0) begin
                streak = 0;
                if (p_ack[m_req]) begin
                    m_comm[m_req] = m_stage;
                    m_req = -1;
                end else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        m_comm[m_req] = m_stage;
                        m_err  = 1'b1;
                        m_eidx = m_req;
                        m_req  = -1;
                    end
                end
            end else begin
                if (p_raw != pp_raw) streak = 0;
                if (req != '0) begin
                    chk("rnd_req_onehot", $countones(req), 1);
                    for (int j = 0; j < NB; j++) begin
                        if (req[j] && m_req < 0) begin
                            m_req   = j;
                            m_stage = p_raw[j] | m_comm[j];
                            m_wait  = 0;
                        end
                    end
                    if (m_req >= 0)
                        chk("rnd_req_needed", m_stage != m_comm[m_req], 1);
                    streak = 0;
                end else if (pending) begin
                    streak++;
                    chk("rnd_scan_latency", streak < NB, 1);
                end
            end
            pp_raw = p_raw;

            if (m_req >= 0) chk("rnd_req", req, ONE << m_req);
            else            chk("rnd_req", req, 0);
            chk("rnd_busy", busy, m_req >= 0);
            chk("rnd_ctrl", ctrl, m_comm);
            chk("rnd_err", err, m_err);
            chk("rnd_eidx", eidx, m_eidx);

            if ($urandom_range(0, 7) == 0) begin
                int j;
                j = $urandom_range(0, NB - 1);
                raw[j] = 8'($urandom) & 8'($urandom) & 8'($urandom);
            end
            ack  = NB'($urandom) & NB'($urandom);
            jtag = ($urandom_range(0, 149) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/reglk_commit.md
REGLK_COMMIT -- requirements
Module: reglk_commit

Interface
REQ-001 SHALL have parameter NB_PERIPHERALS, default 14, number of 8-bit lock bytes.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, cycles to wait for an acknowledge before forced commit; legal range 1..65535.
REQ-003 SHALL have port clk_i  input  1  the single clock; reset is synchronous and active-low.
REQ-004 SHALL have port rst_ni  input  1  synchronous active-low reset.
REQ-005 SHALL have port jtag_unlock  input  1  synchronous clear of committed locks.
REQ-006 SHALL have port reglk_raw_i  input  8*NB_PERIPHERALS  raw lock vector from the lock-register block, byte i for peripheral i.
REQ-007 SHALL have port reglk_ctrl_o  output  8*NB_PERIPHERALS  committed lock vector to peripherals.
REQ-008 SHALL have port upd_req_o  output  NB_PERIPHERALS  per-peripheral lock-update request, level.
REQ-009 SHALL have port upd_ack_i  input  NB_PERIPHERALS  per-peripheral acknowledge, peripheral idle and ready for new lock.
REQ-010 SHALL have port busy_o  output  1  high while a request is outstanding.
REQ-011 SHALL have port err_o  output  1  sticky, set on any acknowledge timeout.
REQ-012 SHALL have port err_idx_o  output  $clog2(NB_PERIPHERALS)  index of the most recent timed-out peripheral.

Function
REQ-013 SHALL keep the committed byte per peripheral in a register; reglk_ctrl_o is that register directly, no combinational path from reglk_raw_i.
REQ-014 SHALL treat lock bits as monotonic: target byte i = reglk_raw_i byte i OR committed byte i; committed bits clear only via reset or jtag_unlock.
REQ-015 SHALL run an FSM with states SCAN and WAIT, plus a scan index idx (0..NB_PERIPHERALS-1).
REQ-016 In SCAN, if target byte idx differs from committed byte idx, the FSM SHALL snapshot the target into a staging register, go to WAIT next cycle, and drive upd_req_o[idx]=1 from that cycle; otherwise idx SHALL advance by one, wrapping NB_PERIPHERALS-1 to 0.
REQ-017 At most one upd_req_o bit SHALL be high at any time; busy_o SHALL equal (state==WAIT).
REQ-018 In WAIT, upd_ack_i[idx]=1 SHALL cause, on that clock edge, committed byte idx <= staging, upd_req_o cleared, idx advanced with wrap, state SCAN.
REQ-019 Changes to reglk_raw_i during WAIT SHALL NOT alter staging; they are picked up on a later scan pass.
REQ-020 A 16-bit wait counter SHALL clear on WAIT entry and increment each WAIT cycle without ack; on reaching ACK_TIMEOUT the block SHALL commit staging anyway (fail-secure), set err_o, load err_idx_o=idx, advance idx, return to SCAN.
REQ-021 Ack and timeout in the same cycle: ack SHALL win, err_o unchanged.
REQ-022 upd_ack_i bits for non-requested peripherals SHALL be ignored.
REQ-023 Worst-case latency from raw change to commit with prompt ack SHALL be NB_PERIPHERALS+2 cycles.
REQ-024 jtag_unlock=1 SHALL, on the next edge, clear all committed bytes and staging, drop upd_req_o, zero counter, set state SCAN, idx 0; err_o and err_idx_o SHALL be retained; jtag_unlock has priority over ack and timeout.

Reset
REQ-025 rst_ni=0 on a clock edge SHALL set reglk_ctrl_o=0, upd_req_o=0, busy_o=0, err_o=0, err_idx_o=0, state SCAN, idx 0, counter 0, staging 0.
REQ-026 Reset mid-WAIT SHALL abort the update without commit; reset has priority over jtag_unlock.

Structure
REQ-027 Package reglk_pkg SHALL hold the FSM state enum, LK_BYTE_W=8, and the default NB_PERIPHERALS.
REQ-028 The wait counter SHALL be a sub-module reglk_timeout_cnt (clear, enable, limit, expired flag); all else inline.

Verification
REQ-029 Reset, raw=0 -> all outputs 0, idx cycles 0..13 continuously.
REQ-030 Raw byte 3 := 0x05, ack[3] asserted 2 cycles after req[3] rises -> reglk_ctrl_o byte 3 = 0x05 on that edge, req[3] falls, err_o=0.
REQ-031 Committed byte 2 = 0x0F, raw byte 2 := 0x30 -> committed becomes 0x3F; raw := 0x00 -> no request, byte stays 0x3F.
REQ-032 Raw byte 7 := 0x01, ack never given, ACK_TIMEOUT=4 -> commit after 4 WAIT cycles, err_o=1, err_idx_o=7.
REQ-033 jtag_unlock pulsed during WAIT on byte 5 with err_o=1 -> next cycle all bytes 0, upd_req_o=0, err_o still 1.
REQ-034 Ack[4] and timeout coincide, plus stray ack[9] -> byte 4 committed, err_o=0, byte 9 unaffected.
